// File: rtl/reimu_move_ctrl.sv
// Player-position controller: samples buttons, moves the sprite centre once per frame at vblank start.
// Optional button debounce is enabled by defining REIMU_DEBOUNCE_EN.
module reimu_move_ctrl #(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned HALF_W     = 15,
  parameter int unsigned HALF_H     = 25,
  parameter int unsigned SPD_FAST   = 4,
  parameter int unsigned SPD_SLOW   = 2,
  parameter int unsigned X_INIT     = 320,
  parameter int unsigned Y_INIT     = 400,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic       clk_25m,
  input  logic       rst,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_focus,
  output logic [9:0] reimux,
  output logic [9:0] reimuy,
  output logic       pos_upd
);

  localparam int unsigned BtnRight = 0;
  localparam int unsigned BtnLeft  = 1;
  localparam int unsigned BtnDown  = 2;
  localparam int unsigned BtnUp    = 3;
  localparam int unsigned BtnFocus = 4;

  localparam logic signed [10:0] SpdFast = 11'(SPD_FAST);
  localparam logic signed [10:0] SpdSlow = 11'(SPD_SLOW);
  localparam logic signed [10:0] XLo     = 11'(HALF_W);
  localparam logic signed [10:0] XHi     = 11'(H_ACT - 1 - HALF_W);
  localparam logic signed [10:0] YLo     = 11'(HALF_H);
  localparam logic signed [10:0] YHi     = 11'(V_ACT - HALF_H);

  typedef enum logic [1:0] {StWait, StMove, StClamp, StCommit} state_e;

  logic [4:0] btn_raw;
  logic [4:0] sync1_q, sync2_q;
  logic [4:0] btn_cond;

  assign btn_raw = {btn_focus, btn_up, btn_down, btn_left, btn_right};

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef REIMU_DEBOUNCE_EN
  localparam logic [17:0] DebLast = 18'(DEB_CYCLES - 1);

  logic [17:0] deb_cnt_q [5];
  logic [4:0]  deb_filt_q;

  // Filtered level flips only after DEB_CYCLES consecutive clocks of disagreement.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      deb_filt_q <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] != deb_filt_q[i]) begin
          if (deb_cnt_q[i] == DebLast) begin
            deb_filt_q[i] <= sync2_q[i];
            deb_cnt_q[i]  <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 18'd1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign btn_cond = deb_filt_q;
`else
  logic unused_deb_cfg;
  assign unused_deb_cfg = ^DEB_CYCLES;
  assign btn_cond = sync2_q;
`endif

  state_e             state_q;
  logic signed [10:0] nx_q, ny_q;
  logic signed [10:0] cx_q, cy_q;
  logic [9:0]         reimux_q, reimuy_q;
  logic               pos_upd_q;

  logic               tick;
  logic signed [10:0] spd, dx, dy;
  logic signed [10:0] nx_d, ny_d;
  logic signed [10:0] cx_d, cy_d;

  assign tick = (vc == 10'(V_ACT)) && (hc == 10'd0);

  always_comb begin
    spd = btn_cond[BtnFocus] ? SpdSlow : SpdFast;
    dx  = '0;
    dy  = '0;
    if (btn_cond[BtnRight]) dx = dx + spd;
    if (btn_cond[BtnLeft])  dx = dx - spd;
    if (btn_cond[BtnDown])  dy = dy + spd;
    if (btn_cond[BtnUp])    dy = dy - spd;
    nx_d = $signed({1'b0, reimux_q}) + dx;
    ny_d = $signed({1'b0, reimuy_q}) + dy;

    cx_d = nx_q;
    if (nx_q < XLo)      cx_d = XLo;
    else if (nx_q > XHi) cx_d = XHi;
    cy_d = ny_q;
    if (ny_q < YLo)      cy_d = YLo;
    else if (ny_q > YHi) cy_d = YHi;
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q   <= StWait;
      nx_q      <= '0;
      ny_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      reimux_q  <= 10'(X_INIT);
      reimuy_q  <= 10'(Y_INIT);
      pos_upd_q <= 1'b0;
    end else begin
      pos_upd_q <= 1'b0;
      unique case (state_q)
        StWait: begin
          if (tick) state_q <= StMove;
        end
        StMove: begin
          nx_q    <= nx_d;
          ny_q    <= ny_d;
          state_q <= StClamp;
        end
        StClamp: begin
          cx_q    <= cx_d;
          cy_q    <= cy_d;
          state_q <= StCommit;
        end
        StCommit: begin
          // Clamped range always fits in 10 bits.
          reimux_q  <= cx_q[9:0];
          reimuy_q  <= cy_q[9:0];
          pos_upd_q <= 1'b1;
          state_q   <= StWait;
        end
        default: state_q <= StWait;
      endcase
    end
  end

  assign reimux  = reimux_q;
  assign reimuy  = reimuy_q;
  assign pos_upd = pos_upd_q;

endmodule

// File: tb/tb_reimu_move_ctrl.sv
// Randomized self-checking bench for reimu_move_ctrl against a frame-level position model.
module tb_reimu_move_ctrl;

  localparam int unsigned TbDeb = 40;
`ifdef REIMU_DEBOUNCE_EN
  localparam int Settle = TbDeb + 6;
`else
  localparam int Settle = 4;
`endif

  logic       clk_25m;
  logic       rst;
  logic [9:0] hc, vc;
  logic       btn_up, btn_down, btn_left, btn_right, btn_focus;
  logic [9:0] reimux, reimuy;
  logic       pos_upd;

  int total = 0;
  int bad   = 0;
  int mx, my;

  logic [9:0] obs_x, obs_y, obs_x_pre;
  logic       obs_pre, obs_upd, obs_post;

  reimu_move_ctrl #(.DEB_CYCLES(TbDeb)) dut (
    .clk_25m  (clk_25m),
    .rst      (rst),
    .hc       (hc),
    .vc       (vc),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_focus(btn_focus),
    .reimux   (reimux),
    .reimuy   (reimuy),
    .pos_upd  (pos_upd)
  );

  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  initial begin
    #(4_000_000);
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // b = {focus, up, down, left, right}
  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_step(input logic [4:0] b);
    int spd;
    spd = b[4] ? 2 : 4;
    mx = clampi(mx + (b[0] ? spd : 0) - (b[1] ? spd : 0), 15, 624);
    my = clampi(my + (b[2] ? spd : 0) - (b[3] ? spd : 0), 25, 455);
  endfunction

  task automatic set_btn(input logic [4:0] b);
    @(negedge clk_25m);
    {btn_focus, btn_up, btn_down, btn_left, btn_right} = b;
    repeat (Settle) @(negedge clk_25m);
  endtask

  // One-clock tick, then capture outputs around the expected commit cycle.
  task automatic run_tick();
    @(negedge clk_25m); vc = 10'd480; hc = 10'd0;
    @(negedge clk_25m); vc = 10'd0;   hc = 10'd5; obs_pre = pos_upd;
    @(negedge clk_25m); obs_pre = obs_pre | pos_upd;
    @(negedge clk_25m); obs_pre = obs_pre | pos_upd; obs_x_pre = reimux;
    @(negedge clk_25m); obs_upd = pos_upd; obs_x = reimux; obs_y = reimuy;
    @(negedge clk_25m); obs_post = pos_upd;
  endtask

  task automatic frame(input logic [4:0] b);
    set_btn(b);
    run_tick();
    model_step(b);
  endtask

  task automatic steer_x(input int target);
    logic [4:0] b;
    int d;
    for (int n = 0; n < 400 && mx != target; n++) begin
      d = target - mx;
      b = (d > 0) ? 5'b00001 : 5'b00010;
      if (d < 4 && d > -4) b[4] = 1'b1;
      frame(b);
    end
  endtask

  task automatic steer_y(input int target);
    logic [4:0] b;
    int d;
    for (int n = 0; n < 400 && my != target; n++) begin
      d = target - my;
      b = (d > 0) ? 5'b00100 : 5'b01000;
      if (d < 4 && d > -4) b[4] = 1'b1;
      frame(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_25m);
    total++; if (reimux !== 10'd320) begin bad++; $display("FAIL reset_x got=%0d exp=320", reimux); end
    total++; if (reimuy !== 10'd400) begin bad++; $display("FAIL reset_y got=%0d exp=400", reimuy); end
    total++; if (pos_upd !== 1'b0) begin bad++; $display("FAIL reset_upd got=%b exp=0", pos_upd); end
    rst = 1'b0;
    mx = 320; my = 400;
    frame(5'b00000);
    total++; if (obs_pre !== 1'b0) begin bad++; $display("FAIL idle_early_upd got=%b exp=0", obs_pre); end
    total++; if (obs_upd !== 1'b1) begin bad++; $display("FAIL idle_upd got=%b exp=1", obs_upd); end
    total++; if (obs_post !== 1'b0) begin bad++; $display("FAIL idle_upd_len got=%b exp=0", obs_post); end
    total++; if (obs_x !== 10'd320 || obs_y !== 10'd400) begin
      bad++; $display("FAIL idle_pos got=(%0d,%0d) exp=(320,400)", obs_x, obs_y);
    end
  endtask

  task automatic test_dirs();
    frame(5'b00001);
    total++; if (obs_x !== 10'd324) begin bad++; $display("FAIL right_x got=%0d exp=324", obs_x); end
    total++; if (obs_x_pre !== 10'd320) begin bad++; $display("FAIL right_early got=%0d exp=320", obs_x_pre); end
    frame(5'b10001);
    total++; if (obs_x !== 10'd326) begin bad++; $display("FAIL focus_right_x got=%0d exp=326", obs_x); end
    frame(5'b01000);
    total++; if (obs_y !== 10'd396) begin bad++; $display("FAIL up_y got=%0d exp=396", obs_y); end
    total++; if (obs_x !== 10'd326) begin bad++; $display("FAIL up_x got=%0d exp=326", obs_x); end
  endtask

  task automatic test_clamp();
    steer_x(622);
    total++; if (reimux !== 10'd622) begin bad++; $display("FAIL setup_622 got=%0d exp=622", reimux); end
    frame(5'b00001);
    total++; if (obs_x !== 10'd624) begin bad++; $display("FAIL clamp_hi_x got=%0d exp=624", obs_x); end
    frame(5'b00001);
    total++; if (obs_x !== 10'd624) begin bad++; $display("FAIL clamp_hi_hold got=%0d exp=624", obs_x); end
    steer_x(15);
    frame(5'b10001);
    total++; if (obs_x !== 10'd17) begin bad++; $display("FAIL setup_17 got=%0d exp=17", obs_x); end
    frame(5'b00010);
    total++; if (obs_x !== 10'd15) begin bad++; $display("FAIL clamp_lo_x got=%0d exp=15", obs_x); end
    steer_y(454);
    total++; if (reimuy !== 10'd454) begin bad++; $display("FAIL setup_454 got=%0d exp=454", reimuy); end
    frame(5'b00100);
    total++; if (obs_y !== 10'd455) begin bad++; $display("FAIL clamp_hi_y got=%0d exp=455", obs_y); end
    steer_y(27);
    frame(5'b01000);
    total++; if (obs_y !== 10'd25) begin bad++; $display("FAIL clamp_lo_y got=%0d exp=25", obs_y); end
  endtask

  task automatic test_opposing();
    logic [9:0] px, py;
    steer_x(300);
    steer_y(200);
    px = reimux; py = reimuy;
    frame(5'b01111);
    total++; if (obs_x !== px || obs_y !== py) begin
      bad++; $display("FAIL opp_fast got=(%0d,%0d) exp=(%0d,%0d)", obs_x, obs_y, px, py);
    end
    total++; if (obs_upd !== 1'b1) begin bad++; $display("FAIL opp_upd got=%b exp=1", obs_upd); end
    frame(5'b11111);
    total++; if (obs_x !== px || obs_y !== py) begin
      bad++; $display("FAIL opp_slow got=(%0d,%0d) exp=(%0d,%0d)", obs_x, obs_y, px, py);
    end
  endtask

  task automatic test_tick_decode();
    logic seen;
    set_btn(5'b00001);
    @(negedge clk_25m); vc = 10'd480; hc = 10'd1;
    @(negedge clk_25m); vc = 10'd479; hc = 10'd0;
    @(negedge clk_25m); vc = 10'd0;   hc = 10'd5;
    seen = 1'b0;
    repeat (6) begin @(negedge clk_25m); seen = seen | pos_upd; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL false_tick_upd got=%b exp=0", seen); end
    total++; if (reimux !== 10'(mx)) begin bad++; $display("FAIL false_tick_x got=%0d exp=%0d", reimux, mx); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    set_btn(5'b00001);
    @(negedge clk_25m); vc = 10'd480; hc = 10'd0;
    @(negedge clk_25m);
    @(negedge clk_25m); vc = 10'd0; hc = 10'd5;
    pulses = 0;
    repeat (8) begin @(negedge clk_25m); if (pos_upd === 1'b1) pulses++; end
    model_step(5'b00001);
    total++; if (pulses != 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    total++; if (reimux !== 10'(mx)) begin bad++; $display("FAIL b2b_x got=%0d exp=%0d", reimux, mx); end
  endtask

  task automatic test_random();
    logic [4:0] b;
    for (int i = 0; i < 40; i++) begin
      b = 5'($urandom_range(0, 31));
      frame(b);
      total++; if (obs_x !== 10'(mx) || obs_y !== 10'(my)) begin
        bad++; $display("FAIL rnd_pos[%0d] b=%b got=(%0d,%0d) exp=(%0d,%0d)", i, b, obs_x, obs_y, mx, my);
      end
      total++; if ({obs_pre, obs_upd, obs_post} !== 3'b010) begin
        bad++; $display("FAIL rnd_upd[%0d] got=%b exp=010", i, {obs_pre, obs_upd, obs_post});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    set_btn(5'b00001);
    @(negedge clk_25m); vc = 10'd480; hc = 10'd0;
    @(negedge clk_25m); vc = 10'd0;   hc = 10'd5;
    @(negedge clk_25m); rst = 1'b1;
    @(negedge clk_25m);
    total++; if (reimux !== 10'd320 || reimuy !== 10'd400) begin
      bad++; $display("FAIL midrst_pos got=(%0d,%0d) exp=(320,400)", reimux, reimuy);
    end
    total++; if (pos_upd !== 1'b0) begin bad++; $display("FAIL midrst_upd got=%b exp=0", pos_upd); end
    rst = 1'b0;
    mx = 320; my = 400;
    seen = 1'b0;
    repeat (6) begin @(negedge clk_25m); seen = seen | pos_upd; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_stale_upd got=%b exp=0", seen); end
    frame(5'b00001);
    total++; if (obs_x !== 10'd324 || obs_upd !== 1'b1) begin
      bad++; $display("FAIL midrst_resume got=(%0d,%b) exp=(324,1)", obs_x, obs_upd);
    end
  endtask

`ifdef REIMU_DEBOUNCE_EN
  task automatic test_debounce();
    logic [9:0] px;
    set_btn(5'b00000);
    px = reimux;
    @(negedge clk_25m); btn_right = 1'b1;
    repeat (TbDeb / 2) @(negedge clk_25m);
    btn_right = 1'b0;
    repeat (Settle) @(negedge clk_25m);
    run_tick();
    total++; if (obs_x !== px) begin bad++; $display("FAIL deb_glitch got=%0d exp=%0d", obs_x, px); end
    frame(5'b00001);
    total++; if (obs_x !== 10'(px + 10'd4)) begin
      bad++; $display("FAIL deb_held got=%0d exp=%0d", obs_x, px + 10'd4);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    hc = 10'd5; vc = 10'd0;
    {btn_focus, btn_up, btn_down, btn_left, btn_right} = 5'b00000;
    mx = 320; my = 400;
    test_reset();
    test_dirs();
    test_clamp();
    test_opposing();
    test_tick_decode();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef REIMU_DEBOUNCE_EN
    test_debounce();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
